ysyx_22040232_mdu: RTL and testbench
====================================

# ysyx_22040232_mdu

Iterative multi-cycle multiply/divide unit for the NPC execute stage; successor to the single-cycle ALU path. It covers the RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU and the W variants) and generalises operand width through `XLEN`. Operations complete over several cycles behind a valid/ready handshake on both input and output, so the pipeline can stall around them. It sits beside the single-cycle ALU in the EXU; the EXU routes M-extension opcodes here and waits on `out_valid`.

## Interface
- `XLEN`, 64: operand and result width; 32 or 64. The W variants exist only when `XLEN` = 64.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request; high only in IDLE.
- `op` input 3: funct3 encoding. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `is_word` input 1: W variant; ignored when `XLEN` = 32.
- `src1` input XLEN: rs1 operand.
- `src2` input XLEN: rs2 operand.
- `flush` input 1: abort the operation in flight (branch redirect).
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer takes the result.
- `result` output XLEN: rd value; registered.

## Operation
- FSM has three states: IDLE, CALC, DONE.
- **IDLE**
  - `in_valid & in_ready` latches `op`, `is_word` and the operands.
  - Fast path (divide by zero or signed overflow) goes to DONE.
  - Otherwise goes to CALC with the iteration counter = ITER.
  - ITER is 32 when `is_word`, else `XLEN`.
- **Word mode operand preparation**
  - Operands are the low 32 bits.
  - Sign-extended for signed ops, zero-extended for unsigned.
- **Signed handling**
  - Signed operands are converted to magnitudes first.
  - The result sign is fixed on the transition into DONE.
  - MULH: both operands signed. MULHSU: `src1` signed, `src2` unsigned. MULHU: both unsigned.
- **Multiply**
  - Shift-add, one multiplier bit per cycle, into a 2·W accumulator (W = 32 in word mode, else `XLEN`).
  - MUL and MULW take the low W bits; MULH* take the high W bits.
- **Divide**
  - Restoring, one quotient bit per cycle.
  - Quotient sign = sign(src1) XOR sign(src2); remainder sign = sign(src1).
- **Fast path** (RISC-V defined results, no iteration)
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (most negative / −1): quotient = dividend, remainder 0.
- **Word mode result**
  - The 32-bit result is sign-extended to 64 bits, for every W op including DIVUW and REMUW.
- **CALC**
  - The counter decrements each cycle.
  - At count 1 the state moves to DONE and `result` is loaded.
- **DONE**
  - `out_valid` = 1 and `result` is stable.
  - `out_valid & out_ready` returns to IDLE.
- **Flush**
  - `flush` in CALC or DONE forces IDLE on the next edge; no `out_valid` follows for that request.
  - `flush` in IDLE blocks acceptance that cycle.
  - `flush` has priority over the handshakes.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, counter 0.
- Reset asserted mid-operation discards the request immediately.
- Accept in cycle 0:
  - Iterative ops: CALC in cycles 1..ITER, `out_valid` high from cycle ITER+1 (cycle 65 for XLEN ops, 33 for W ops).
  - Fast path: `out_valid` high from cycle 1.
- Throughput is one request in flight; no new accept while `out_valid` is high.
- `in_ready` returns in the cycle after the output handshake, so there is no IDLE bypass.
- `in_ready` and `out_valid` are never both high.
- The output holds indefinitely under `out_ready` = 0.

## Structure
- Opcode constants, ITER values and FSM state encodings go in the shared defines file alongside the existing `ysyx_22040232_INST_*` macros.
- One sub-module: `ysyx_22040232_mdu_abs`, a parametrised conditional two's-complement block. It is instantiated for operand magnitudes and for result sign correction.

## Test plan
- MUL, 7 × −3 → `result` 0xFFFFFFFFFFFFFFEB; `out_valid` first high in cycle 65.
- MULHU, 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 0xFFFFFFFFFFFFFFFE. MULHSU, −1 × 2 → 0xFFFFFFFFFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFFFFFFFFFD; REM −7 % 2 → 0xFFFFFFFFFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Fast path, each with `out_valid` in cycle 1:
  - DIVU 5 / 0 → all-ones; REM 5 % 0 → 5.
  - DIV 0x8000000000000000 / −1 → 0x8000000000000000; REM → 0.
- Word mode: MULW 0x7FFFFFFF × 2 → 0xFFFFFFFFFFFFFFFE in cycle 33; DIVUW 0xFFFFFFFF / 1 → 0xFFFFFFFFFFFFFFFF.
- Control:
  - `out_ready` held 0 for 10 cycles → `result` stable and `in_ready` 0 throughout.
  - `flush` in CALC cycle 20 → `in_ready` 1 next cycle, no `out_valid`.
  - `rst` low in cycle 30 → all outputs at reset values immediately.

Source files
------------

// File: rtl/ysyx_22040232_mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: funct3 opcodes,
// word-mode iteration count, FSM encoding and operand signedness helpers.
package ysyx_22040232_mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int ITER_WORD = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic src1_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: return 1'b0;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic src2_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM:                       return 1'b1;
            OP_MUL, OP_MULHSU, OP_MULHU, OP_DIVU, OP_REMU: return 1'b0;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040232_mdu_abs.sv
// Conditional two's-complement: passes value through or negates it.
// Used both to form operand magnitudes and to restore the result sign.
module ysyx_22040232_mdu_abs #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] converted
);

    // Negate on request, otherwise forward unchanged
    always_comb begin
        if (negate) begin
            converted = ~value + W'(1);
        end else begin
            converted = value;
        end
    end

endmodule

// File: rtl/ysyx_22040232_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, valid/ready on both sides and flush abort.
module ysyx_22040232_mdu
    import ysyx_22040232_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int DW    = 2 * XLEN;

    mdu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [XLEN-1:0]  result_r;

    logic [2:0]       op_r;
    logic             word_r;
    logic             neg_r;
    logic [XLEN-1:0]  opa_r;
    logic [XLEN-1:0]  opb_r;
    logic [XLEN-1:0]  rem_r;
    logic [DW-1:0]    mcand_r;
    logic [DW-1:0]    acc_r;

    logic             word_s;
    logic             accept_s;
    logic [XLEN-1:0]  a_ext_s;
    logic [XLEN-1:0]  b_ext_s;
    logic             sa_s;
    logic             sb_s;
    logic [XLEN-1:0]  a_mag_s;
    logic [XLEN-1:0]  b_mag_s;
    logic [XLEN-1:0]  min_neg_s;
    logic             div0_s;
    logic             ovf_s;
    logic [XLEN-1:0]  fast_res_s;

    logic [DW-1:0]    acc_nxt_s;
    logic [XLEN:0]    rem_sh_s;
    logic [XLEN:0]    rem_diff_s;
    logic [XLEN-1:0]  rem_nxt_s;
    logic [XLEN-1:0]  q_nxt_s;
    logic [DW-1:0]    corr_in_s;
    logic [DW-1:0]    corr_s;
    logic [XLEN-1:0]  raw_s;
    logic [XLEN-1:0]  calc_res_s;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Every W-variant result is the low word sign-extended, unsigned ones included
    function automatic logic [XLEN-1:0] res_fmt(input logic [XLEN-1:0] v, input logic w);
        if (w) begin
            return sext32(v[31:0]);
        end else begin
            return v;
        end
    endfunction

    assign word_s   = (XLEN == 64) && is_word;
    assign accept_s = in_valid && in_ready_r && !flush;

    // Operand extension, signs and the RISC-V defined fast-path results
    always_comb begin
        if (word_s) begin
            a_ext_s   = src1_signed(op) ? sext32(src1[31:0]) : zext32(src1[31:0]);
            b_ext_s   = src2_signed(op) ? sext32(src2[31:0]) : zext32(src2[31:0]);
            min_neg_s = sext32(32'h8000_0000);
        end else begin
            a_ext_s   = src1;
            b_ext_s   = src2;
            min_neg_s = {1'b1, {(XLEN-1){1'b0}}};
        end
        sa_s   = src1_signed(op) & a_ext_s[XLEN-1];
        sb_s   = src2_signed(op) & b_ext_s[XLEN-1];
        div0_s = op[2] && (b_ext_s == {XLEN{1'b0}});
        ovf_s  = (op == OP_DIV || op == OP_REM) && (a_ext_s == min_neg_s)
                 && (b_ext_s == {XLEN{1'b1}});
        if (div0_s) begin
            fast_res_s = op[1] ? res_fmt(a_ext_s, word_s) : {XLEN{1'b1}};
        end else if (ovf_s) begin
            fast_res_s = op[1] ? {XLEN{1'b0}} : res_fmt(a_ext_s, word_s);
        end else begin
            fast_res_s = {XLEN{1'b0}};
        end
    end

    ysyx_22040232_mdu_abs #(.W(XLEN)) u_abs_a (
        .value     (a_ext_s),
        .negate    (sa_s),
        .converted (a_mag_s)
    );

    ysyx_22040232_mdu_abs #(.W(XLEN)) u_abs_b (
        .value     (b_ext_s),
        .negate    (sb_s),
        .converted (b_mag_s)
    );

    // One iteration step of both datapaths plus selection of the value to sign-correct
    always_comb begin
        if (opa_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
        rem_sh_s   = {rem_r, opa_r[XLEN-1]};
        rem_diff_s = rem_sh_s - {1'b0, opb_r};
        if (rem_diff_s[XLEN]) begin
            rem_nxt_s = rem_sh_s[XLEN-1:0];
            q_nxt_s   = {opa_r[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt_s = rem_diff_s[XLEN-1:0];
            q_nxt_s   = {opa_r[XLEN-2:0], 1'b1};
        end
        if (op_r[2]) begin
            corr_in_s = op_r[1] ? {{XLEN{1'b0}}, rem_nxt_s} : {{XLEN{1'b0}}, q_nxt_s};
        end else begin
            corr_in_s = acc_nxt_s;
        end
    end

    // Full-width negation so MULH* see a correct high half
    ysyx_22040232_mdu_abs #(.W(DW)) u_abs_res (
        .value     (corr_in_s),
        .negate    (neg_r),
        .converted (corr_s)
    );

    // Pick low or high half of the corrected value and apply word formatting
    always_comb begin
        if (op_r[2] || op_r == OP_MUL) begin
            raw_s = corr_s[XLEN-1:0];
        end else if (word_r) begin
            raw_s = XLEN'(corr_s[63:32]);
        end else begin
            raw_s = corr_s[DW-1:XLEN];
        end
        calc_res_s = res_fmt(raw_s, word_r);
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (div0_s || ovf_s) begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= fast_res_s;
                        end else begin
                            state_r <= ST_CALC;
                            cnt_r   <= word_s ? CNT_W'(ITER_WORD) : CNT_W'(XLEN);
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b1;
                    end else if (cnt_r == CNT_W'(1)) begin
                        state_r     <= ST_DONE;
                        cnt_r       <= {CNT_W{1'b0}};
                        out_valid_r <= 1'b1;
                        result_r    <= calc_res_s;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch on accept, then one multiplier or quotient bit per CALC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r    <= OP_MUL;
            word_r  <= 1'b0;
            neg_r   <= 1'b0;
            opa_r   <= {XLEN{1'b0}};
            opb_r   <= {XLEN{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            mcand_r <= {DW{1'b0}};
            acc_r   <= {DW{1'b0}};
        end else if (accept_s) begin
            op_r    <= op;
            word_r  <= word_s;
            neg_r   <= (op[2] && op[1]) ? sa_s : (sa_s ^ sb_s);
            opb_r   <= b_mag_s;
            rem_r   <= {XLEN{1'b0}};
            acc_r   <= {DW{1'b0}};
            mcand_r <= {{XLEN{1'b0}}, a_mag_s};
            if (op[2]) begin
                // Word dividends are left-aligned so bits shift out from bit XLEN-1
                opa_r <= word_s ? (a_mag_s << ITER_WORD) : a_mag_s;
            end else begin
                opa_r <= b_mag_s;
            end
        end else if (state_r == ST_CALC) begin
            if (op_r[2]) begin
                rem_r <= rem_nxt_s;
                opa_r <= q_nxt_s;
            end else begin
                acc_r   <= acc_nxt_s;
                mcand_r <= {mcand_r[DW-2:0], 1'b0};
                opa_r   <= {1'b0, opa_r[XLEN-1:1]};
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_ysyx_22040232_mdu.sv
// Self-checking bench for ysyx_22040232_mdu: directed cases, randomized ops
// against an arithmetic reference model, and flush/reset/backpressure control.
module tb_ysyx_22040232_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic        is_word = 1'b0;
    logic [63:0] src1 = 64'd0;
    logic [63:0] src2 = 64'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22040232_mdu #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // in_ready and out_valid must never be high together
    always @(negedge clk) check_eq("rdy_vld_excl", {63'd0, in_ready & out_valid}, 64'd0);

    // Reference results straight from the RV64M definitions
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  ua, ub, r;
        int           sa, sb;
        longint       la, lb;
        logic         ovf32, ovf64;
        ua = a[31:0];
        ub = b[31:0];
        sa = a[31:0];
        sb = b[31:0];
        la = a;
        lb = b;
        ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        if (w) begin
            case (o)
                3'd0: r = ua * ub;
                3'd4: if (ub == 32'd0) r = 32'hFFFF_FFFF; else if (ovf32) r = ua; else r = sa / sb;
                3'd5: if (ub == 32'd0) r = 32'hFFFF_FFFF; else r = ua / ub;
                3'd6: if (ub == 32'd0) r = ua; else if (ovf32) r = 32'd0; else r = sa % sb;
                3'd7: if (ub == 32'd0) r = ua; else r = ua % ub;
                default: r = 32'd0;
            endcase
            return {{32{r[31]}}, r};
        end
        case (o)
            3'd0: return a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            3'd4: if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF; else if (ovf64) return a; else return la / lb;
            3'd5: if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF; else return a / b;
            3'd6: if (b == 64'd0) return a; else if (ovf64) return 64'd0; else return la % lb;
            3'd7: if (b == 64'd0) return a; else return a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic sgn;
        sgn = (o == 3'd4) || (o == 3'd6);
        if (o[2]) begin
            if (w && (b[31:0] == 32'd0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)))
                return 1;
            if (!w && (b == 64'd0 || (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
                return 1;
        end
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return {$urandom, 32'h8000_0000};
            5: return {32'd0, 32'($urandom_range(0, 20))};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one request, measure latency, hold the output, then take it
    task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                          input int hold, input string tag);
        int lat;
        @(negedge clk);
        check_eq($sformatf("%s.in_ready", tag), {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op       = o;
        is_word  = w;
        src1     = a;
        src2     = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("%s.out_valid", tag), {63'd0, out_valid}, 64'd1);
        check_eq($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
        check_eq($sformatf("%s.result", tag), result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s.hold_result", tag), result, exp);
            check_eq($sformatf("%s.hold_flags", tag), {62'd0, in_ready, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq($sformatf("%s.after_take", tag), {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic        w;
        logic [63:0] a, b;
        int          seen;

        repeat (3) @(negedge clk);
        check_eq("reset.flags", {62'd0, in_ready, out_valid}, 64'd2);
        check_eq("reset.result", result, 64'd0);
        rst = 1'b1;

        run_op(3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0, "mul");
        run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 65, 1, "mulhu");
        run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, "mulhsu");
        run_op(3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, "div");
        run_op(3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, "rem");
        run_op(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 10, "divu_hold10");
        run_op(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65, 0, "remu");
        run_op(3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, "divu_by0");
        run_op(3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0, "rem_by0");
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1, 0, "div_ovf");
        run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, "rem_ovf");
        run_op(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0, "mulw");
        run_op(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0, "divuw");

        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(0, 1));
            if (w) begin
                case ($urandom_range(0, 4))
                    0: o = 3'd0;
                    1: o = 3'd4;
                    2: o = 3'd5;
                    3: o = 3'd6;
                    default: o = 3'd7;
                endcase
            end else begin
                o = 3'($urandom_range(0, 7));
            end
            a = pick_operand();
            b = pick_operand();
            run_op(o, w, a, b, ref_res(o, w, a, b), ref_lat(o, w, a, b),
                   $urandom_range(0, 3), $sformatf("rnd%0d_op%0d_w%0d", k, o, w));
        end

        // Flush while in CALC cycle 20
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; is_word = 1'b0; src1 = 64'd123; src2 = 64'd456;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("flush.in_calc", {62'd0, in_ready, out_valid}, 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush.next_cycle", {62'd0, in_ready, out_valid}, 64'd2);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_eq("flush.no_out_valid", 64'(seen), 64'd0);

        // Reset asserted in cycle 30 of a divide
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; is_word = 1'b0; src1 = 64'd999; src2 = 64'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_mid.flags", {62'd0, in_ready, out_valid}, 64'd2);
        check_eq("rst_mid.result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(3'd4, 1'b0, 64'd999, 64'd3, 64'd333, 65, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
